// File: rtl/cpld_multirom_sel_pkg.sv
// Shared types and constants for the CPC multi-ROM selector: write FSM states,
// ROM-select register width and the DFxx port decode level.
package cpld_multirom_sel_pkg;

   localparam int ROMSEL_W = 8;

   // The ROM-select port lives at DFxx; only A13 low distinguishes it here.
   localparam logic DFXX_ADR13 = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CAPT = 2'd1,
      ST_HOLD = 2'd2
   } wr_state_e;

endpackage

// File: rtl/cpld_multirom_sel_if.sv
// Z80-side bus as seen by the ROM selector: address bits, strobes, data
// and the external config-port decode.
interface cpld_multirom_sel_if;

   logic       adr15;
   logic       adr14;
   logic       adr13;
   logic       ioreq_b;
   logic       wr_b;
   logic       romen_b;
   logic [7:0] data;
   logic       cfg_wr_sel;

   modport master (
      output adr15, adr14, adr13, ioreq_b, wr_b, romen_b, data, cfg_wr_sel
   );

   modport slave (
      input adr15, adr14, adr13, ioreq_b, wr_b, romen_b, data, cfg_wr_sel
   );

endinterface

// File: rtl/cpld_iowr_oneshot.sv
// One-shot IO write detector: turns an arbitrarily long IO write into a single
// capture strobe, re-arming only once the write strobe has gone away.
module cpld_iowr_oneshot
   import cpld_multirom_sel_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      iowr,
   input  logic      wr_hit,
   output logic      capt,
   output wr_state_e state
);

   wr_state_e state_q;
   wr_state_e state_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      capt    = 1'b0;
      case (state_q)
         ST_IDLE: if (iowr && wr_hit) state_d = ST_CAPT;
         ST_CAPT: begin
            capt    = 1'b1;
            state_d = ST_HOLD;
         end
         ST_HOLD: if (!iowr) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign state = state_q;

endmodule

// File: rtl/cpld_multirom_sel.sv
// Upper/lower ROM selector for NUM_SKT dual-image sockets: captures the ROM-select
// and slot-enable registers from IO writes and decodes socket CS, A14/pin27 and ROMDIS.
module cpld_multirom_sel
   import cpld_multirom_sel_pkg::*;
#(
   parameter int NUM_SKT  = 4,
   parameter int GRP_W    = 2,
   parameter bit LOROM_OK = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   cpld_multirom_sel_if.slave    bus,
   input  logic [2*NUM_SKT-1:0]  slot_dip,
   input  logic [GRP_W-1:0]      grp_dip,
   input  logic [NUM_SKT-1:0]    big_dip,
   input  logic                  lorom_en,
   output logic                  romdis,
   output logic [NUM_SKT-1:0]    skt_cs_b,
   output logic [NUM_SKT-1:0]    skt_p27,
   output logic                  roma14,
   output logic                  romoe_b,
   output logic [ROMSEL_W-1:0]   romsel_q,
   output wr_state_e             wr_state
);

   localparam int NSLOT = 2 * NUM_SKT;

   logic                iowr;
   logic                wr_hit;
   logic                capt;
   logic [ROMSEL_W-1:0] romsel_d;
   logic [NSLOT-1:0]    slot_en_q;
   logic [NSLOT-1:0]    slot_en_d;
   logic [NSLOT-1:0]    sel;
   logic [NUM_SKT-1:0]  odd_sel;
   logic                lorom_mode;
   logic                unused_adr15;

   assign iowr         = !bus.ioreq_b && !bus.wr_b;
   assign wr_hit       = (bus.adr13 == DFXX_ADR13) || bus.cfg_wr_sel;
   assign unused_adr15 = bus.adr15;

   cpld_iowr_oneshot u_oneshot (
      .clk    (clk),
      .reset  (reset),
      .iowr   (iowr),
      .wr_hit (wr_hit),
      .capt   (capt),
      .state  (wr_state)
   );

   always_comb begin
      romsel_d  = romsel_q;
      slot_en_d = slot_en_q;
      if (capt) begin
         if (bus.adr13 == DFXX_ADR13) romsel_d = bus.data;
         if (bus.cfg_wr_sel)          slot_en_d = NSLOT'(bus.data) & slot_dip;
      end
   end

   // Slot enables come out of reset following the straps, so the board works before any config write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         romsel_q  <= '0;
         slot_en_q <= slot_dip;
      end else begin
         romsel_q  <= romsel_d;
         slot_en_q <= slot_en_d;
      end
   end

   assign lorom_mode = LOROM_OK && lorom_en && (grp_dip == '0);

   for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      logic [15:0] tgt;
      logic        hit;
      // Targets beyond 8 bits can never equal the register, so the high byte must be zero.
      assign tgt = 16'(grp_dip) * 16'(NSLOT) + 16'(i);
      assign hit = bus.adr14 && slot_en_q[i] && (tgt[15:8] == 8'd0) && (tgt[7:0] == romsel_q);
      if (i == 0) begin : g_lo
         assign sel[i] = bus.adr14 ? (hit && !lorom_mode) : (lorom_mode && slot_en_q[0]);
      end else begin : g_up
         assign sel[i] = hit;
      end
   end

   for (genvar s = 0; s < NUM_SKT; s++) begin : g_skt
      assign skt_cs_b[s] = !(sel[2*s] || sel[2*s+1]);
      assign odd_sel[s]  = sel[2*s+1];
      assign skt_p27[s]  = big_dip[s] ? roma14 : 1'b1;
   end

   assign roma14  = |odd_sel;
   assign romdis  = |sel;
   assign romoe_b = bus.romen_b;

endmodule
